ps2_kbd_cmd_seq: RTL

Command sequencer between the PS/2 keyboard controller and the game's key decoder. After reset it sends the keyboard reset command (FF) and waits for the acknowledge (FA) and the self-test pass (AA). It then sets the keyboard LEDs on request (ED + argument), retrying on resend, error or timeout. Scan-code bytes not consumed as command responses pass through to the key decoder.

---
 rtl/ps2_kbd_pkg.sv | 25 ++
 rtl/ps2_kbd_cmd_seq_if.sv | 24 ++
 rtl/ps2_resp_timer.sv | 20 ++
 rtl/ps2_kbd_cmd_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: byte constants, sequencer states and state helpers
package ps2_kbd_pkg;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_ERR     = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  // Each SEND state is directly followed by its ACK state in the encoding.
  typedef enum logic [2:0] {
    S_INIT_SEND, S_INIT_ACK, S_INIT_BAT, S_IDLE,
    S_LED_SEND, S_LED_ACK, S_ARG_SEND, S_ARG_ACK
  } state_e;
  function automatic logic is_send(state_e s);
    return s inside {S_INIT_SEND, S_LED_SEND, S_ARG_SEND};
  endfunction
  function automatic logic is_ack(state_e s);
    return s inside {S_INIT_ACK, S_LED_ACK, S_ARG_ACK};
  endfunction
  // SEND state that retransmits the byte owned by s
  function automatic state_e send_of(state_e s);
    return s inside {S_LED_SEND, S_LED_ACK} ? S_LED_SEND :
           s inside {S_ARG_SEND, S_ARG_ACK} ? S_ARG_SEND : S_INIT_SEND;
  endfunction
endpackage

// File: rtl/ps2_kbd_cmd_seq_if.sv
// ps2_kbd_cmd_seq_if: LED request, PS/2 controller and key decoder signals
interface ps2_kbd_cmd_seq_if;
  logic       led_req;
  logic [2:0] led_val;
  logic [7:0] ps2_cmd;
  logic       ps2_send;
  logic       ps2_cmd_sent;
  logic       ps2_timeout;
  logic [7:0] ps2_rx_data;
  logic       ps2_rx_en;
  logic [7:0] key_data;
  logic       key_valid;
  logic       ready;
  logic       busy;
  logic       error;
  modport master (
    output led_req, led_val, ps2_cmd_sent, ps2_timeout, ps2_rx_data, ps2_rx_en,
    input  ps2_cmd, ps2_send, key_data, key_valid, ready, busy, error
  );
  modport slave (
    input  led_req, led_val, ps2_cmd_sent, ps2_timeout, ps2_rx_data, ps2_rx_en,
    output ps2_cmd, ps2_send, key_data, key_valid, ready, busy, error
  );
endinterface

// File: rtl/ps2_resp_timer.sv
// ps2_resp_timer: loadable down-counter flagging when it reads zero
module ps2_resp_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over counting; the count parks at zero
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/ps2_kbd_cmd_seq.sv
// ps2_kbd_cmd_seq: keyboard reset/LED command sequencer with scan-code forwarding
module ps2_kbd_cmd_seq
  import ps2_kbd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int MAX_RETRY   = 3
) (
  input logic               CLOCK_50,
  input logic               reset,
  ps2_kbd_cmd_seq_if.slave  bus
);
  localparam int TW = $clog2(BAT_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d;
  logic [2:0]    led_q, led_d;
  logic [7:0]    cmd_q, cmd_d, kdata_q, kdata_d;
  logic          send_q, send_d, kvalid_q, kvalid_d, ready_q, ready_d, error_q, error_d;
  logic          fa, fe, fc, aa, ack, bat, done, tx_fail, consumed, fail, go_led, tload, expired;
  logic [TW-1:0] tval;
  ps2_resp_timer #(.W(TW)) u_timer (
    .clk(CLOCK_50), .rst(reset), .load(tload), .load_val(tval),
    .en(ack || bat), .expired(expired)
  );
  // response decode, retry handling, LED pending latch and forwarding
  always_comb begin
    fa       = bus.ps2_rx_en && bus.ps2_rx_data == RSP_ACK;
    fe       = bus.ps2_rx_en && bus.ps2_rx_data == RSP_RESEND;
    fc       = bus.ps2_rx_en && bus.ps2_rx_data == RSP_ERR;
    aa       = bus.ps2_rx_en && bus.ps2_rx_data == RSP_BAT_OK;
    ack      = is_ack(state_q);
    bat      = state_q == S_INIT_BAT;
    done     = send_q && bus.ps2_cmd_sent;
    tx_fail  = send_q && bus.ps2_timeout;
    consumed = ack ? (fa || fe || fc) : bat ? (aa || fc) : 1'b0;
    fail     = tx_fail || (ack && !fa && (fe || fc || expired)) || (bat && !aa && (fc || expired));
    go_led   = state_q == S_IDLE && pend_q && ready_q;
    tload    = done || (state_q == S_INIT_ACK && fa);
    tval     = done ? TW'(ACK_TIMEOUT) : TW'(BAT_TIMEOUT);
    state_d  = state_q;
    retry_d  = retry_q;
    error_d  = error_q;
    ready_d  = ready_q || (bat && aa);
    pend_d   = bus.led_req ? 1'b1 : go_led ? 1'b0 : pend_q;
    led_d    = bus.led_req ? bus.led_val : led_q;
    if (fail) begin
      if (int'(retry_q) + 1 < MAX_RETRY) begin
        retry_d = retry_q + RW'(1);
        state_d = send_of(state_q);
      end else begin
        error_d = 1'b1;
        retry_d = '0;
        state_d = S_IDLE;
      end
    end else if (done || (ack && fa)) begin
      state_d = state_q == S_ARG_ACK ? S_IDLE : state_e'(state_q + 3'd1);
      retry_d = fa ? '0 : retry_q;
    end else if (bat && aa) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else if (go_led) begin
      state_d = S_LED_SEND;
    end
    send_d   = is_send(state_q) && !done && !tx_fail;
    cmd_d    = is_send(state_q) && !send_q ?
               (state_q == S_INIT_SEND ? CMD_RESET : state_q == S_LED_SEND ? CMD_SET_LED : {5'b0, led_q}) :
               cmd_q;
    kvalid_d = bus.ps2_rx_en && !consumed;
    kdata_d  = kvalid_d ? bus.ps2_rx_data : kdata_q;
  end
  // state and output registers; reset abandons any sequence immediately
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q  <= S_INIT_SEND;
      retry_q  <= '0;
      pend_q   <= 1'b0;
      led_q    <= '0;
      cmd_q    <= '0;
      send_q   <= 1'b0;
      kdata_q  <= '0;
      kvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      pend_q   <= pend_d;
      led_q    <= led_d;
      cmd_q    <= cmd_d;
      send_q   <= send_d;
      kdata_q  <= kdata_d;
      kvalid_q <= kvalid_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  assign bus.ps2_cmd   = cmd_q;
  assign bus.ps2_send  = send_q;
  assign bus.key_data  = kdata_q;
  assign bus.key_valid = kvalid_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.error     = error_q;
endmodule
